// File: rtl/nco_quad_lut.sv
// nco_quad_lut - quadrature NCO with a quarter-wave sine ROM.
//
// A PHASE_BITS accumulator advances by the current increment whenever
// `enable` is high. Its top LUT_BITS bits, after adding a static phase
// offset, address a quarter-wave magnitude table. Quadrant folding yields
// signed sine and cosine samples three cycles after the phase register.
// A new increment is accepted through a valid/ready handshake. It only
// takes effect when the accumulator wraps, so retuning keeps the phase
// continuous.
//
// Ports
//   CLK, RST     clock, asynchronous active-high reset
//   enable       advance the accumulator this cycle
//   inc_data     requested phase increment
//   inc_valid    inc_data is valid
//   inc_ready    an increment can be accepted
//   phase_ofs    static phase offset, added before lookup
//   sin, cos     signed OUT_BITS samples
//   out_valid    sin/cos belong to an enabled accumulator step
//   dbg_state_o  retune FSM state (0 = IDLE, 1 = PEND)
//   dbg_phase_o  accumulator value
//
// Handshake: a transfer happens on a rising CLK edge where inc_valid and
// inc_ready are both high. inc_ready is a register. It is high only in IDLE
// and never depends combinationally on inc_valid. inc_data must be stable
// while inc_valid is high.
//
// Build option: define NCO_DITHER_EN to add a 16-bit LFSR phase dither
// before truncation. Latency is unchanged.
//
// The ROM contents are computed at elaboration from
// T[i] = round((2^(OUT_BITS-1)-1) * sin(2*pi*(i+0.5)/2^LUT_BITS)),
// so no external memory image is required.

module nco_quad_lut #(
  parameter int PHASE_BITS = 26,
  parameter int LUT_BITS   = 8,
  parameter int OUT_BITS   = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       enable,
  input  logic [PHASE_BITS-1:0]      inc_data,
  input  logic                       inc_valid,
  output logic                       inc_ready,
  input  logic [PHASE_BITS-1:0]      phase_ofs,
  output logic signed [OUT_BITS-1:0] sin,
  output logic signed [OUT_BITS-1:0] cos,
  output logic                       out_valid,
  output logic                       dbg_state_o,
  output logic [PHASE_BITS-1:0]      dbg_phase_o
);

  localparam int DEPTH = 1 << (LUT_BITS - 2);
  localparam int KW    = LUT_BITS - 2;

  // Fixed-point sine on a 2^30 scale, using a Taylor series up to x^13.
  // The argument never exceeds pi/2, so the truncation error stays far
  // below one output LSB.
  function automatic logic [OUT_BITS-2:0] rom_entry(input int i);
    longint x, x2, term, acc, amp, r;
    x    = (64'sd3373259426 * longint'(2 * i + 1)) >>> LUT_BITS;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 6; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      acc  = acc + term;
    end
    amp = (longint'(1) << (OUT_BITS - 1)) - 1;
    r   = (acc * amp + (longint'(1) << 29)) >>> 30;
    return r[OUT_BITS-2:0];
  endfunction

  logic [OUT_BITS-2:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [OUT_BITS-2:0] VAL = rom_entry(g);
    assign rom[g] = VAL;
  end

  // ---------------------------------------------------------------
  // Accumulator and retune FSM
  // ---------------------------------------------------------------
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic [PHASE_BITS-1:0] inc_cur_q, inc_cur_d;
  logic [PHASE_BITS-1:0] inc_pend_q, inc_pend_d;
  logic                  inc_ready_q;
  logic [PHASE_BITS:0]   phase_sum;
  logic                  wrap;
  logic                  accept;
  logic                  commit;

  always_comb begin
    phase_sum = {1'b0, phase_q} + {1'b0, inc_cur_q};
    wrap      = enable & phase_sum[PHASE_BITS];
    phase_d   = enable ? phase_sum[PHASE_BITS-1:0] : phase_q;
  end

  always_comb begin
    state_d    = state_q;
    inc_cur_d  = inc_cur_q;
    inc_pend_d = inc_pend_q;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        accept = inc_valid & inc_ready_q;
        if (accept) begin
          inc_pend_d = inc_data;
          state_d    = PEND;
        end
      end
      PEND: begin
        // With a zero increment the accumulator never wraps, so the
        // pending value commits right away instead of stalling forever.
        commit = wrap | (inc_cur_q == '0);
        if (commit) begin
          inc_cur_d = inc_pend_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      inc_cur_q   <= '0;
      inc_pend_q  <= '0;
      inc_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      inc_cur_q   <= inc_cur_d;
      inc_pend_q  <= inc_pend_d;
      // Registered so that it stays low through reset and rises on the
      // first edge after release.
      inc_ready_q <= (state_d == IDLE);
    end
  end

  // ---------------------------------------------------------------
  // Optional dither source
  // ---------------------------------------------------------------
  logic [PHASE_BITS-1:0] dith;

`ifdef NCO_DITHER_EN
  // Mask keeping the low PHASE_BITS-LUT_BITS bits of the zero-padded LFSR.
  localparam logic [PHASE_BITS+15:0] DMASK =
    {{16{1'b0}}, {PHASE_BITS{1'b1}}} >> LUT_BITS;

  logic [15:0]            lfsr_q;
  logic [PHASE_BITS+15:0] lfsr_ext;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_comb begin
    lfsr_ext = {{PHASE_BITS{1'b0}}, lfsr_q};
    dith     = PHASE_BITS'(lfsr_ext & DMASK);
  end
`else
  assign dith = '0;
`endif

  // ---------------------------------------------------------------
  // Lookup pipeline: S1 fold, S2 ROM read, S3 sign
  // ---------------------------------------------------------------
  logic [PHASE_BITS-1:0] s1_sum;
  logic [LUT_BITS-1:0]   s1_p;
  logic [1:0]            s1_qs, s1_qc;
  logic [KW-1:0]         s1_k;
  logic [KW-1:0]         idx_s_d, idx_c_d;

  always_comb begin
    s1_sum  = phase_q + phase_ofs + dith;
    s1_p    = LUT_BITS'(s1_sum >> (PHASE_BITS - LUT_BITS));
    s1_qs   = s1_p[LUT_BITS-1 -: 2];
    s1_qc   = s1_qs + 2'd1;
    s1_k    = s1_p[KW-1:0];
    // Odd quadrants read the table backwards.
    idx_s_d = s1_qs[0] ? ~s1_k : s1_k;
    idx_c_d = s1_qc[0] ? ~s1_k : s1_k;
  end

  logic [KW-1:0]       idx_s_q, idx_c_q;
  logic                neg_s1_q, neg_c1_q;
  logic [OUT_BITS-2:0] mag_s_q, mag_c_q;
  logic                neg_s2_q, neg_c2_q;
  logic [OUT_BITS-1:0] sin_d, cos_d;
  logic [OUT_BITS-1:0] sin_q, cos_q;
  logic                en1_q, en2_q, out_valid_q;

  // The magnitude is at most 2^(OUT_BITS-1)-1, so negation cannot overflow.
  always_comb begin
    sin_d = neg_s2_q ? -{1'b0, mag_s_q} : {1'b0, mag_s_q};
    cos_d = neg_c2_q ? -{1'b0, mag_c_q} : {1'b0, mag_c_q};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_s_q     <= '0;
      idx_c_q     <= '0;
      neg_s1_q    <= 1'b0;
      neg_c1_q    <= 1'b0;
      mag_s_q     <= '0;
      mag_c_q     <= '0;
      neg_s2_q    <= 1'b0;
      neg_c2_q    <= 1'b0;
      sin_q       <= '0;
      cos_q       <= '0;
      en1_q       <= 1'b0;
      en2_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      idx_s_q     <= idx_s_d;
      idx_c_q     <= idx_c_d;
      neg_s1_q    <= s1_qs[1];
      neg_c1_q    <= s1_qc[1];
      mag_s_q     <= rom[idx_s_q];
      mag_c_q     <= rom[idx_c_q];
      neg_s2_q    <= neg_s1_q;
      neg_c2_q    <= neg_c1_q;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      en1_q       <= enable;
      en2_q       <= en1_q;
      out_valid_q <= en2_q;
    end
  end

  assign inc_ready   = inc_ready_q;
  assign sin         = sin_q;
  assign cos         = cos_q;
  assign out_valid   = out_valid_q;
  assign dbg_state_o = (state_q == PEND);
  assign dbg_phase_o = phase_q;

endmodule

// File: tb/tb_nco_quad_lut.sv
// Directed testbench for nco_quad_lut with default parameters
// (PHASE_BITS=26, LUT_BITS=8, OUT_BITS=8; T[0]=2, T[26]=77, T[37]=101, T[63]=127).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_nco_quad_lut;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        enable = 1'b0;
  logic        inc_valid = 1'b0;
  logic [25:0] inc_data = '0;
  logic [25:0] phase_ofs = '0;

  logic              inc_ready;
  logic              out_valid;
  logic              dbg_state;
  logic signed [7:0] sin_o;
  logic signed [7:0] cos_o;
  logic [25:0]       dbg_phase;

  int checks = 0;
  int errors = 0;

  nco_quad_lut dut (
    .CLK         (CLK),
    .RST         (RST),
    .enable      (enable),
    .inc_data    (inc_data),
    .inc_valid   (inc_valid),
    .inc_ready   (inc_ready),
    .phase_ofs   (phase_ofs),
    .sin         (sin_o),
    .cos         (cos_o),
    .out_valid   (out_valid),
    .dbg_state_o (dbg_state),
    .dbg_phase_o (dbg_phase)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  // Leaves the bench on the falling edge where RST was released.
  task automatic do_reset();
    RST       = 1'b1;
    enable    = 1'b0;
    inc_valid = 1'b0;
    inc_data  = '0;
    phase_ofs = '0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1;
    tick();
    checks++;
    if (sin_o !== 8'sd0 || cos_o !== 8'sd0) begin
      errors++;
      $display("FAIL reset_outputs: sin=%0d cos=%0d expected 0 0", sin_o, cos_o);
    end
    checks++;
    if (out_valid !== 1'b0 || inc_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%b inc_ready=%b expected 0 0", out_valid, inc_ready);
    end
    checks++;
    if (dbg_phase !== 26'd0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: phase=%0h state=%b expected 0 0", dbg_phase, dbg_state);
    end
    do_reset();
    checks++;
    if (inc_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_release: inc_ready=%b expected 0", inc_ready);
    end
    tick();
    checks++;
    if (inc_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_first_edge: inc_ready=%b expected 1", inc_ready);
    end
  endtask

  task automatic test_quarter_turn();
    int es[4] = '{2, 127, -2, -127};
    int ec[4] = '{127, -2, -127, 2};
    do_reset();
    enable = 1'b1;
    tick();
    checks++;
    if (inc_ready !== 1'b1) begin
      errors++;
      $display("FAIL qt_ready_idle: inc_ready=%b expected 1", inc_ready);
    end
    inc_valid = 1'b1;
    inc_data  = 26'h100_0000;
    tick();
    inc_valid = 1'b0;
    checks++;
    if (inc_ready !== 1'b0 || dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL qt_pend: inc_ready=%b state=%b expected 0 1", inc_ready, dbg_state);
    end
    tick();
    checks++;
    if (inc_ready !== 1'b1 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL qt_commit: inc_ready=%b state=%b expected 1 0", inc_ready, dbg_state);
    end
    tick();
    tick();
    tick();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (sin_o !== 8'(es[j % 4]) || cos_o !== 8'(ec[j % 4]) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL qt_sample%0d: sin=%0d cos=%0d ov=%b expected %0d %0d 1",
                 j, sin_o, cos_o, out_valid, es[j % 4], ec[j % 4]);
      end
      tick();
    end
  endtask

  task automatic test_enable();
    do_reset();
    tick();
    inc_valid = 1'b1;
    inc_data  = 26'h100_0000;
    tick();
    inc_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || sin_o !== 8'sd2 || cos_o !== 8'sd127) begin
      errors++;
      $display("FAIL en_idle: ov=%b sin=%0d cos=%0d expected 0 2 127", out_valid, sin_o, cos_o);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_lat1: out_valid=%b expected 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_lat2: out_valid=%b expected 0", out_valid);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || sin_o !== 8'sd2 || cos_o !== 8'sd127) begin
      errors++;
      $display("FAIL en_first: ov=%b sin=%0d cos=%0d expected 1 2 127", out_valid, sin_o, cos_o);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || sin_o !== 8'sd127 || cos_o !== -8'sd2) begin
      errors++;
      $display("FAIL en_second: ov=%b sin=%0d cos=%0d expected 1 127 -2", out_valid, sin_o, cos_o);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || sin_o !== -8'sd2 || cos_o !== -8'sd127 || dbg_phase !== 26'h200_0000) begin
        errors++;
        $display("FAIL en_hold%0d: ov=%b sin=%0d cos=%0d phase=%0h expected 0 -2 -127 2000000",
                 j, out_valid, sin_o, cos_o, dbg_phase);
      end
    end
  endtask

  task automatic test_retune_at_wrap();
    do_reset();
    tick();
    inc_valid = 1'b1;
    inc_data  = 26'h10_0000;
    tick();
    inc_valid = 1'b0;
    tick();
    inc_valid = 1'b1;
    inc_data  = 26'h20_0000;
    tick();
    inc_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (inc_ready !== 1'b0 || dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL rt_pend_hold: inc_ready=%b state=%b expected 0 1", inc_ready, dbg_state);
    end
    enable = 1'b1;
    for (int j = 1; j < 64; j++) begin
      tick();
      checks++;
      if (dbg_phase !== 26'(j << 20) || inc_ready !== 1'b0) begin
        errors++;
        $display("FAIL rt_step%0d: phase=%0h ready=%b expected %0h 0", j, dbg_phase, inc_ready, 26'(j << 20));
      end
    end
    tick();
    checks++;
    if (dbg_phase !== 26'd0 || inc_ready !== 1'b1 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL rt_wrap: phase=%0h ready=%b state=%b expected 0 1 0", dbg_phase, inc_ready, dbg_state);
    end
    tick();
    checks++;
    if (dbg_phase !== 26'h20_0000) begin
      errors++;
      $display("FAIL rt_new1: phase=%0h expected 200000", dbg_phase);
    end
    tick();
    checks++;
    if (dbg_phase !== 26'h40_0000) begin
      errors++;
      $display("FAIL rt_new2: phase=%0h expected 400000", dbg_phase);
    end
  endtask

  task automatic test_from_zero();
    do_reset();
    enable = 1'b1;
    tick();
    inc_valid = 1'b1;
    inc_data  = 26'd5;
    tick();
    inc_valid = 1'b0;
    checks++;
    if (dbg_phase !== 26'd0 || dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL fz_accept: phase=%0d state=%b expected 0 1", dbg_phase, dbg_state);
    end
    tick();
    checks++;
    if (dbg_phase !== 26'd0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL fz_commit: phase=%0d state=%b expected 0 0", dbg_phase, dbg_state);
    end
    for (int j = 1; j <= 3; j++) begin
      tick();
      checks++;
      if (dbg_phase !== 26'(5 * j)) begin
        errors++;
        $display("FAIL fz_step%0d: phase=%0d expected %0d", j, dbg_phase, 5 * j);
      end
    end
  endtask

  task automatic test_phase_offset();
    do_reset();
    tick();
    inc_valid = 1'b1;
    inc_data  = 26'(37 << 18);
    tick();
    inc_valid = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    checks++;
    if (dbg_phase !== 26'(37 << 18)) begin
      errors++;
      $display("FAIL po_phase: phase=%0h expected %0h", dbg_phase, 26'(37 << 18));
    end
    repeat (4) tick();
    checks++;
    if (sin_o !== 8'sd101 || cos_o !== 8'sd77) begin
      errors++;
      $display("FAIL po_base: sin=%0d cos=%0d expected 101 77", sin_o, cos_o);
    end
    phase_ofs = 26'h200_0000;
    repeat (3) tick();
    checks++;
    if (sin_o !== -8'sd101 || cos_o !== -8'sd77) begin
      errors++;
      $display("FAIL po_half_turn: sin=%0d cos=%0d expected -101 -77", sin_o, cos_o);
    end
    phase_ofs = 26'd0;
    repeat (3) tick();
    checks++;
    if (sin_o !== 8'sd101 || cos_o !== 8'sd77) begin
      errors++;
      $display("FAIL po_restore: sin=%0d cos=%0d expected 101 77", sin_o, cos_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1;
    tick();
    inc_valid = 1'b1;
    inc_data  = 26'h100_0000;
    tick();
    inc_valid = 1'b0;
    tick();
    inc_valid = 1'b1;
    inc_data  = 26'h10_0000;
    tick();
    inc_valid = 1'b0;
    checks++;
    if (dbg_state !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_setup: state=%b ov=%b expected 1 1", dbg_state, out_valid);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (sin_o !== 8'sd0 || cos_o !== 8'sd0 || out_valid !== 1'b0 || inc_ready !== 1'b0) begin
      errors++;
      $display("FAIL ar_immediate: sin=%0d cos=%0d ov=%b ready=%b expected 0 0 0 0",
               sin_o, cos_o, out_valid, inc_ready);
    end
    checks++;
    if (dbg_phase !== 26'd0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL ar_state: phase=%0h state=%b expected 0 0", dbg_phase, dbg_state);
    end
    tick();
    RST = 1'b0;
    checks++;
    if (inc_ready !== 1'b0) begin
      errors++;
      $display("FAIL ar_ready_release: inc_ready=%b expected 0", inc_ready);
    end
    tick();
    checks++;
    if (inc_ready !== 1'b1 || dbg_phase !== 26'd0) begin
      errors++;
      $display("FAIL ar_restart1: ready=%b phase=%0h expected 1 0", inc_ready, dbg_phase);
    end
    tick();
    checks++;
    if (dbg_phase !== 26'd0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL ar_restart2: phase=%0h state=%b expected 0 0", dbg_phase, dbg_state);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tick();
    test_reset();
    test_quarter_turn();
    test_enable();
    test_retune_at_wrap();
    test_from_zero();
    test_phase_offset();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
